lcd_ram_arb: RTL and testbench
==============================

Name: lcd_ram_arb

Overview:
- Single-port frame-RAM arbiter and sequencer for the LCD controller.
- Shares one 13-bit-address, 8-bit-data RAM between three requesters:
  - panel refresh read (R)
  - STN capture write (W), i.e. the timing-detector write port
  - host/MCU access (H)
- Sits between the capture/refresh engines and the frame-buffer RAM macro.
- Generates RAM strobes, returns read data and issues one-cycle acks.

Parameters:
- AW, 13, RAM address width.
- DW, 8, RAM data width.
- RD_LAT, 1, RAM read latency in cycles (1..3), from the ram_cs read cycle to ram_rdata valid.
- HOLD_MAX, 15, host wait cycles after which H is promoted above W.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active high
- r_req  in  1  refresh read request, held until r_ack
- r_addr  in  AW  refresh read address
- r_ack  out  1  one-cycle pulse; r_rdata valid in the same cycle
- r_rdata  out  DW  refresh read data
- w_req  in  1  capture write request, held until w_ack
- w_addr  in  AW  capture write address
- w_wdata  in  DW  capture write data
- w_ack  out  1  one-cycle write-done pulse
- cap_en  in  1  capture enable; 0 = W writes are discarded
- h_req  in  1  host request, held until h_ack
- h_we  in  1  host write (1) / read (0)
- h_addr  in  AW  host address
- h_wdata  in  DW  host write data
- h_ack  out  1  one-cycle pulse; h_rdata valid in the same cycle for reads
- h_rdata  out  DW  host read data
- ram_cs  out  1  RAM chip select, one cycle per access
- ram_we  out  1  RAM write enable, qualified by ram_cs
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data, RD_LAT cycles after a read ram_cs

Behaviour:
- Reset values (rst high, asynchronous):
  - state IDLE
  - all acks and ram_cs/ram_we at 0
  - ram_addr, ram_wdata, r_rdata, h_rdata at 0
  - host wait counter at 0
- A reset mid-access aborts the access; no ack is ever issued for the aborted access.
- Handshake:
  - A requester holds req and its address/data stable until its ack.
  - A requester drops req on the clock edge that samples ack high.
  - The arbiter evaluates requests only in IDLE, so a just-acked requester is never re-granted on a stale req.
- FSM states: IDLE, WR, RD, RWAIT, ACK.
- IDLE, grant priority:
  - R first.
  - Then W, except that H beats W when hwait == HOLD_MAX.
  - Then H.
  - Address, data and owner are registered at grant.
- IDLE transitions:
  - Write grant (W, or H with h_we=1): go to WR.
  - Read grant: go to RD.
  - No request: stay in IDLE.
- WR:
  - ram_cs=1, ram_we=1; the owner's ack is asserted in this cycle; then go to IDLE.
  - Write latency: req seen in IDLE at cycle N gives RAM write plus ack at N+1.
- W with cap_en=0:
  - Granted normally; WR asserts w_ack with ram_cs=0 and ram_we=0.
  - The capture side is never stalled and the RAM is untouched.
  - cap_en is sampled at grant.
- RD: ram_cs=1, ram_we=0 for one cycle, then RWAIT.
- RWAIT:
  - Counts RD_LAT cycles.
  - On the last count, ram_rdata is registered into the owner's rdata register; then go to ACK.
- ACK: the owner's ack=1 for exactly one cycle with rdata stable; then go to IDLE.
- Read latency: req in IDLE at N gives ack at N+2+RD_LAT.
- r_rdata/h_rdata hold their value until the next read completion of the same port.
- Host wait counter:
  - Increments each cycle h_req=1 and H is not granted; saturates at HOLD_MAX.
  - Clears when H is granted or h_req=0.
- Promotion never pre-empts R and never aborts an access in flight.
- Simultaneous requests in IDLE resolve by the priority above; losers simply stay pending.
- Exactly one ack is asserted per cycle at most; ram_cs is never high in IDLE or ACK.
- Addresses are passed through unchecked; range policy belongs to the requesters.

Decomposition:
- Shared package lcd_ram_pkg:
  - AW and DW defaults
  - owner encoding OWN_R=2'd0, OWN_W=2'd1, OWN_H=2'd2
  - FSM state encoding
  - HOLD_MAX default
- A separate priority/promotion sub-module is not natural at this size; keep a single module.

Test Plan:
- Single W (addr 0x0123, data 0xA5), cap_en=1 -> ram_cs=ram_we=1 with addr 0x0123/data 0xA5 one cycle after req; w_ack pulses in that same cycle; next cycle IDLE.
- R and W asserted in the same cycle, RD_LAT=1, RAM holding 0x5C at 0x0010 -> R served first: r_ack at N+3 with r_rdata=0x5C; W written afterwards.
- H read held while W is re-requested every cycle after each ack -> after 15 wait cycles H is granted ahead of W; h_ack arrives and the counter clears.
- cap_en=0, W to 0x04FF -> w_ack in the cycle after grant, ram_cs=0; a later read of 0x04FF returns its previous contents.
- rst asserted during RWAIT of an H read -> all outputs return to 0 immediately; no h_ack; after release a new R completes normally.
- RD_LAT=3 host read -> h_ack exactly 5 cycles after req is seen in IDLE; h_rdata stable during ack and held afterwards.

Source files
------------

// File: rtl/lcd_ram_arb_pkg.sv
// Shared definitions for the LCD frame-RAM arbiter: default widths, owner and FSM state encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lcd_ram_pkg;

  localparam int AW_DEF       = 13;
  localparam int DW_DEF       = 8;
  localparam int HOLD_MAX_DEF = 15;

  typedef enum logic [1:0] {
    OWN_R = 2'd0,
    OWN_W = 2'd1,
    OWN_H = 2'd2
  } owner_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    RWAIT = 3'd3,
    ACK   = 3'd4
  } state_e;

endpackage

// File: rtl/lcd_ram_arb_if.sv
// Bundle of the three requester ports plus the frame-RAM port of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: req held until one-cycle ack; RAM side has no backpressure.
// Modports: slave = arbiter side, master = requesters and RAM macro side.
interface lcd_ram_arb_if
  import lcd_ram_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  // panel refresh read
  logic          r_req;
  logic [AW-1:0] r_addr;
  logic          r_ack;
  logic [DW-1:0] r_rdata;
  // capture write
  logic          w_req;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic          w_ack;
  logic          cap_en;
  // host access
  logic          h_req;
  logic          h_we;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic          h_ack;
  logic [DW-1:0] h_rdata;
  // frame RAM
  logic          ram_cs;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  r_req, r_addr, w_req, w_addr, w_wdata, cap_en,
           h_req, h_we, h_addr, h_wdata, ram_rdata,
    output r_ack, r_rdata, w_ack, h_ack, h_rdata,
           ram_cs, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output r_req, r_addr, w_req, w_addr, w_wdata, cap_en,
           h_req, h_we, h_addr, h_wdata, ram_rdata,
    input  r_ack, r_rdata, w_ack, h_ack, h_rdata,
           ram_cs, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/lcd_ram_arb.sv
// Single-port frame-RAM arbiter: refresh read (R) > capture write (W) > host (H), H promoted over W after HOLD_MAX waits.
// Latency: write ack 1 cycle after grant cycle; read ack 2+RD_LAT cycles after grant cycle.
// Backpressure: requesters hold req/addr/data until their one-cycle ack; losers simply stay pending.
// Ports: clk, rst (async, active high), bus (lcd_ram_arb_if.slave: R/W/H requester ports and RAM port).
module lcd_ram_arb
  import lcd_ram_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int RD_LAT   = 1,
  parameter int HOLD_MAX = HOLD_MAX_DEF
)(
  input logic          clk,
  input logic          rst,
  lcd_ram_arb_if.slave bus
);

  localparam int HW = $clog2(HOLD_MAX + 1);

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          wen_q, wen_d;       // write actually reaches the RAM (cleared for discarded captures)
  logic [1:0]    lat_q, lat_d;
  logic [HW-1:0] hwait_q, hwait_d;
  logic [DW-1:0] r_rdata_q, r_rdata_d;
  logic [DW-1:0] h_rdata_q, h_rdata_d;

  logic promote;
  logic h_grant;
  logic h_busy;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_R;
      addr_q    <= '0;
      wdata_q   <= '0;
      wen_q     <= 1'b0;
      lat_q     <= '0;
      hwait_q   <= '0;
      r_rdata_q <= '0;
      h_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wen_q     <= wen_d;
      lat_q     <= lat_d;
      hwait_q   <= hwait_d;
      r_rdata_q <= r_rdata_d;
      h_rdata_q <= h_rdata_d;
    end
  end

  assign promote = (hwait_q == HW'(HOLD_MAX));
  // While H's own access is in flight it is being served, so it must not accumulate wait credit.
  assign h_busy  = (state_q != IDLE) && (owner_q == OWN_H);

  // Next-state and grant logic
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wen_d     = wen_q;
    lat_d     = lat_q;
    r_rdata_d = r_rdata_q;
    h_rdata_d = h_rdata_q;
    h_grant   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.r_req) begin
          owner_d = OWN_R;
          addr_d  = bus.r_addr;
          state_d = RD;
        end else if (bus.w_req && !(bus.h_req && promote)) begin
          owner_d = OWN_W;
          addr_d  = bus.w_addr;
          wdata_d = bus.w_wdata;
          wen_d   = bus.cap_en;
          state_d = WR;
        end else if (bus.h_req) begin
          h_grant = 1'b1;
          owner_d = OWN_H;
          addr_d  = bus.h_addr;
          wdata_d = bus.h_wdata;
          wen_d   = 1'b1;
          state_d = bus.h_we ? WR : RD;
        end
      end
      RD: begin
        lat_d   = 2'(RD_LAT - 1);
        state_d = RWAIT;
      end
      RWAIT: begin
        if (lat_q == 2'd0) begin
          if (owner_q == OWN_R) r_rdata_d = bus.ram_rdata;
          else                  h_rdata_d = bus.ram_rdata;
          state_d = ACK;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      WR:      state_d = IDLE;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (!bus.h_req || h_grant || h_busy) hwait_d = '0;
    else if (!promote)                   hwait_d = hwait_q + HW'(1);
    else                                 hwait_d = hwait_q;
  end

  // Outputs decoded from state and owner
  always_comb begin
    bus.ram_cs    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.r_ack     = 1'b0;
    bus.w_ack     = 1'b0;
    bus.h_ack     = 1'b0;
    bus.ram_addr  = addr_q;
    bus.ram_wdata = wdata_q;
    bus.r_rdata   = r_rdata_q;
    bus.h_rdata   = h_rdata_q;
    case (state_q)
      WR: begin
        bus.ram_cs = wen_q;
        bus.ram_we = wen_q;
        bus.w_ack  = (owner_q == OWN_W);
        bus.h_ack  = (owner_q == OWN_H);
      end
      RD: bus.ram_cs = 1'b1;
      ACK: begin
        bus.r_ack = (owner_q == OWN_R);
        bus.h_ack = (owner_q == OWN_H);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lcd_ram_arb.sv
module tb_lcd_ram_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  lcd_ram_arb_if bus_a ();
  lcd_ram_arb_if bus_b ();

  lcd_ram_arb #(.RD_LAT(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  lcd_ram_arb #(.RD_LAT(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // RAM models: read data valid RD_LAT cycles after a read chip-select cycle
  logic [7:0] mem_a [0:8191];
  logic [7:0] mem_b [0:8191];
  logic [7:0] rd_a;
  logic [7:0] p1_b, p2_b, p3_b;

  always @(posedge clk) begin
    if (bus_a.ram_cs && bus_a.ram_we) mem_a[bus_a.ram_addr] <= bus_a.ram_wdata;
    rd_a <= (bus_a.ram_cs && !bus_a.ram_we) ? mem_a[bus_a.ram_addr] : 8'hEE;
    if (bus_b.ram_cs && bus_b.ram_we) mem_b[bus_b.ram_addr] <= bus_b.ram_wdata;
    p1_b <= (bus_b.ram_cs && !bus_b.ram_we) ? mem_b[bus_b.ram_addr] : 8'hEE;
    p2_b <= p1_b;
    p3_b <= p2_b;
  end
  assign bus_a.ram_rdata = rd_a;
  assign bus_b.ram_rdata = p3_b;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until the selected ack of instance A is seen; n = ticks taken or -1 on timeout.
  task automatic wait_ack_a(input int which, output int n, output int w_seen);
    bit found;
    found  = 1'b0;
    n      = -1;
    w_seen = 0;
    for (int k = 1; k <= 60 && !found; k++) begin
      tick();
      if ((which == 0 && bus_a.r_ack) || (which == 1 && bus_a.w_ack) ||
          (which == 2 && bus_a.h_ack)) begin
        found = 1'b1;
        n     = k;
      end else if (bus_a.w_ack) begin
        w_seen++;
      end
    end
  endtask

  initial begin
    int n;
    int ws;

    for (int i = 0; i < 8192; i++) begin
      mem_a[i] = 8'(i + 17);
      mem_b[i] = 8'(i + 17);
    end
    mem_a[16'h0010] = 8'h5C;

    bus_a.r_req = 0; bus_a.r_addr = '0; bus_a.w_req = 0; bus_a.w_addr = '0;
    bus_a.w_wdata = '0; bus_a.cap_en = 1; bus_a.h_req = 0; bus_a.h_we = 0;
    bus_a.h_addr = '0; bus_a.h_wdata = '0;
    bus_b.r_req = 0; bus_b.r_addr = '0; bus_b.w_req = 0; bus_b.w_addr = '0;
    bus_b.w_wdata = '0; bus_b.cap_en = 1; bus_b.h_req = 0; bus_b.h_we = 0;
    bus_b.h_addr = '0; bus_b.h_wdata = '0;

    // Reset state
    tick(); tick();
    check("rst_ram_cs", bus_a.ram_cs, 0);
    check("rst_ram_we", bus_a.ram_we, 0);
    check("rst_acks", {bus_a.r_ack, bus_a.w_ack, bus_a.h_ack}, 0);
    check("rst_ram_addr", bus_a.ram_addr, 0);
    check("rst_rdata", {bus_a.r_rdata, bus_a.h_rdata}, 0);
    rst = 0;
    tick();

    // Single capture write
    bus_a.w_req = 1; bus_a.w_addr = 13'h0123; bus_a.w_wdata = 8'hA5; bus_a.cap_en = 1;
    tick();
    check("w1_cs_we", {bus_a.ram_cs, bus_a.ram_we}, 2'b11);
    check("w1_addr", bus_a.ram_addr, 13'h0123);
    check("w1_wdata", bus_a.ram_wdata, 8'hA5);
    check("w1_ack", bus_a.w_ack, 1);
    tick();
    bus_a.w_req = 0;
    check("w1_ack_pulse", bus_a.w_ack, 0);
    check("w1_cs_idle", bus_a.ram_cs, 0);
    check("w1_mem", mem_a[13'h0123], 8'hA5);

    // R and W together: R first, W afterwards
    bus_a.r_req = 1; bus_a.r_addr = 13'h0010;
    bus_a.w_req = 1; bus_a.w_addr = 13'h0200; bus_a.w_wdata = 8'h77;
    wait_ack_a(0, n, ws);
    check("rw_r_lat", n, 3);
    check("rw_w_before_r", ws, 0);
    check("rw_r_rdata", bus_a.r_rdata, 8'h5C);
    tick();
    bus_a.r_req = 0;
    wait_ack_a(1, n, ws);
    check("rw_w_lat", n, 1);
    check("rw_w_addr", bus_a.ram_addr, 13'h0200);
    tick();
    bus_a.w_req = 0;
    check("rw_w_mem", mem_a[13'h0200], 8'h77);

    // Host promotion over a continuously requesting W
    bus_a.h_req = 1; bus_a.h_we = 0; bus_a.h_addr = 13'h0ABC;
    bus_a.w_req = 1; bus_a.w_addr = 13'h0300; bus_a.w_wdata = 8'h42;
    wait_ack_a(2, n, ws);
    check("pr_h_cycle", n, 19);
    check("pr_w_acks", ws, 8);
    check("pr_h_rdata", bus_a.h_rdata, 8'hCD);
    check("pr_hwait_clr", dut_a.hwait_q, 0);
    tick();
    bus_a.h_req = 0; bus_a.w_req = 0;
    check("pr_h_ack_pulse", bus_a.h_ack, 0);

    // Discarded capture write
    bus_a.w_req = 1; bus_a.w_addr = 13'h04FF; bus_a.w_wdata = 8'h99; bus_a.cap_en = 0;
    tick();
    check("cd_ack", bus_a.w_ack, 1);
    check("cd_cs_we", {bus_a.ram_cs, bus_a.ram_we}, 0);
    tick();
    bus_a.w_req = 0; bus_a.cap_en = 1;
    bus_a.h_req = 1; bus_a.h_we = 0; bus_a.h_addr = 13'h04FF;
    wait_ack_a(2, n, ws);
    check("cd_rd_lat", n, 3);
    check("cd_rd_data", bus_a.h_rdata, 8'h10);
    tick();
    bus_a.h_req = 0;

    // Reset during RWAIT of a host read
    bus_a.h_req = 1; bus_a.h_we = 0; bus_a.h_addr = 13'h0020;
    tick();
    check("ra_rd_cs", bus_a.ram_cs, 1);
    tick();
    rst = 1;
    #1;
    check("ra_cs", bus_a.ram_cs, 0);
    check("ra_acks", {bus_a.r_ack, bus_a.w_ack, bus_a.h_ack}, 0);
    check("ra_rdata", {bus_a.r_rdata, bus_a.h_rdata}, 0);
    check("ra_addr", bus_a.ram_addr, 0);
    bus_a.h_req = 0;
    tick();
    check("ra_no_hack1", bus_a.h_ack, 0);
    tick();
    check("ra_no_hack2", bus_a.h_ack, 0);
    rst = 0;
    tick();
    bus_a.r_req = 1; bus_a.r_addr = 13'h0010;
    wait_ack_a(0, n, ws);
    check("ra_r_lat", n, 3);
    check("ra_r_rdata", bus_a.r_rdata, 8'h5C);
    tick();
    bus_a.r_req = 0;

    // RD_LAT=3 host read on instance B
    bus_b.h_req = 1; bus_b.h_we = 0; bus_b.h_addr = 13'h0155;
    n = -1;
    for (int k = 1; k <= 30 && n < 0; k++) begin
      tick();
      if (bus_b.h_ack) n = k;
    end
    check("l3_lat", n, 5);
    check("l3_rdata_ack", bus_b.h_rdata, 8'h66);
    tick();
    bus_b.h_req = 0;
    check("l3_ack_pulse", bus_b.h_ack, 0);
    check("l3_rdata_hold1", bus_b.h_rdata, 8'h66);
    tick(); tick();
    check("l3_rdata_hold2", bus_b.h_rdata, 8'h66);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
